// File: rtl/grid_tracker_pkg.sv
// Shared constants and width helpers for the shadow-frame tracker and the renderer.
package grid_tracker_pkg;
  localparam int GRID_W_DEF = 16;
  localparam int GRID_H_DEF = 12;
  localparam int N_OBJ_DEF  = 4;

  typedef enum logic [2:0] {
    CODE_EMPTY = 3'd0,
    CODE_OBJ1  = 3'd1,
    CODE_OBJ2  = 3'd2,
    CODE_OBJ3  = 3'd3,
    CODE_OBJ4  = 3'd4
  } code_t;

  function automatic int code_w(input int n_obj);
    return $clog2(n_obj + 1);
  endfunction

  function automatic int xw(input int grid_w);
    return $clog2(grid_w);
  endfunction

  function automatic int yw(input int grid_h);
    return $clog2(grid_h);
  endfunction

  function automatic int cw(input int grid_w, input int grid_h);
    return $clog2(grid_w * grid_h + 1);
  endfunction
endpackage

// File: rtl/grid_diff_tracker_if.sv
// Scan-side and update-side signals between the cell walker, the tracker and the drawing engine.
interface grid_diff_tracker_if #(
  parameter int N_OBJ  = 4,
  parameter int XW     = 4,
  parameter int YW     = 4,
  parameter int CODE_W = 3,
  parameter int CW     = 8
);
  logic [N_OBJ-1:0]  obj_req;
  logic              enable;
  logic              scan_ready;
  logic              clear;
  logic              refresh;
  logic [XW-1:0]     cur_x;
  logic [YW-1:0]     cur_y;
  logic              upd_valid;
  logic              upd_ready;
  logic [XW-1:0]     upd_x;
  logic [YW-1:0]     upd_y;
  logic [CODE_W-1:0] upd_code;
  logic              frame_done;
  logic [CW-1:0]     diff_count;

  modport master (
    output obj_req, enable, clear, refresh, upd_ready,
    input  scan_ready, cur_x, cur_y, upd_valid, upd_x, upd_y, upd_code, frame_done, diff_count
  );

  modport slave (
    input  obj_req, enable, clear, refresh, upd_ready,
    output scan_ready, cur_x, cur_y, upd_valid, upd_x, upd_y, upd_code, frame_done, diff_count
  );
endinterface

// File: rtl/grid_shadow_mem.sv
// Previous-frame copy: combinational read at the cursor, one synchronous write, bulk clear.
module grid_shadow_mem #(
  parameter int GRID_W = 16,
  parameter int GRID_H = 12,
  parameter int CODE_W = 3,
  parameter int XW     = 4,
  parameter int YW     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [XW-1:0]     rd_x,
  input  logic [YW-1:0]     rd_y,
  output logic [CODE_W-1:0] rd_data,
  input  logic              we,
  input  logic [XW-1:0]     wr_x,
  input  logic [YW-1:0]     wr_y,
  input  logic [CODE_W-1:0] wr_data
);
  localparam int CELLS = GRID_W * GRID_H;
  localparam int AW    = $clog2(CELLS);

  logic [CODE_W-1:0] mem_q [CELLS];
  logic [CODE_W-1:0] mem_d [CELLS];
  logic [AW-1:0]     rd_idx, wr_idx;

  assign rd_idx  = AW'(rd_y) * AW'(GRID_W) + AW'(rd_x);
  assign wr_idx  = AW'(wr_y) * AW'(GRID_W) + AW'(wr_x);
  assign rd_data = mem_q[rd_idx];

  always_comb begin
    mem_d = mem_q;
    if (clr) begin
      for (int i = 0; i < CELLS; i++) mem_d[i] = '0;
    end else if (we) begin
      mem_d[wr_idx] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CELLS; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end
endmodule

// File: rtl/grid_diff_tracker.sv
// Raster walker that compares resolved cell codes to the shadow frame and emits changed cells.
module grid_diff_tracker
  import grid_tracker_pkg::*;
#(
  parameter int GRID_W = GRID_W_DEF,
  parameter int GRID_H = GRID_H_DEF,
  parameter int N_OBJ  = N_OBJ_DEF
) (
  input logic clk,
  input logic rst,
  grid_diff_tracker_if.slave bus
);
  localparam int CODE_W = code_w(N_OBJ);
  localparam int XW     = xw(GRID_W);
  localparam int YW     = yw(GRID_H);
  localparam int CW     = cw(GRID_W, GRID_H);
  localparam int CELLS  = GRID_W * GRID_H;

  logic [XW-1:0]     cur_x_q, cur_x_d, upd_x_q, upd_x_d;
  logic [YW-1:0]     cur_y_q, cur_y_d, upd_y_q, upd_y_d;
  logic [CODE_W-1:0] upd_code_q, upd_code_d, code_new, code_old;
  logic [CW-1:0]     cnt_q, cnt_d, cnt_inc, diff_q, diff_d;
  logic              upd_valid_q, upd_valid_d, frame_done_q, frame_done_d;
  logic              refresh_pend_q, refresh_pend_d, refresh_active_q, refresh_active_d;
  logic              scan_ready, accept, last_x, last_y, at_origin, report, changed;

  grid_shadow_mem #(
    .GRID_W(GRID_W), .GRID_H(GRID_H), .CODE_W(CODE_W), .XW(XW), .YW(YW)
  ) u_mem (
    .clk(clk), .rst(rst), .clr(bus.clear),
    .rd_x(cur_x_q), .rd_y(cur_y_q), .rd_data(code_old),
    .we(accept && !bus.clear), .wr_x(cur_x_q), .wr_y(cur_y_q), .wr_data(code_new)
  );

  // Highest set request bit wins; later iterations override earlier ones.
  always_comb begin
    code_new = CODE_W'(CODE_EMPTY);
    for (int i = 0; i < N_OBJ; i++) begin
      if (bus.obj_req[i]) code_new = CODE_W'(i + 1);
    end
  end

  assign scan_ready = !(upd_valid_q && !bus.upd_ready);
  assign accept     = bus.enable && scan_ready;
  assign last_x     = cur_x_q == XW'(GRID_W - 1);
  assign last_y     = cur_y_q == YW'(GRID_H - 1);
  assign at_origin  = (cur_x_q == '0) && (cur_y_q == '0);
  // The origin accept that arms a refresh frame already reports.
  assign report     = refresh_active_q || (at_origin && refresh_pend_q);
  assign changed    = (code_new != code_old) || report;
  assign cnt_inc    = (changed && cnt_q != CW'(CELLS)) ? cnt_q + 1'b1 : cnt_q;

  always_comb begin
    cur_x_d          = cur_x_q;
    cur_y_d          = cur_y_q;
    upd_valid_d      = upd_valid_q;
    upd_x_d          = upd_x_q;
    upd_y_d          = upd_y_q;
    upd_code_d       = upd_code_q;
    cnt_d            = cnt_q;
    diff_d           = diff_q;
    frame_done_d     = 1'b0;
    refresh_pend_d   = refresh_pend_q;
    refresh_active_d = refresh_active_q;
    if (upd_valid_q && bus.upd_ready) upd_valid_d = 1'b0;
    if (bus.clear) begin
      cur_x_d     = '0;
      cur_y_d     = '0;
      cnt_d       = '0;
      upd_valid_d = 1'b0;
    end else if (accept) begin
      if (changed) begin
        upd_valid_d = 1'b1;
        upd_x_d     = cur_x_q;
        upd_y_d     = cur_y_q;
        upd_code_d  = code_new;
      end
      if (at_origin && refresh_pend_q) begin
        refresh_active_d = 1'b1;
        refresh_pend_d   = 1'b0;
      end
      if (last_x) begin
        cur_x_d = '0;
        cur_y_d = last_y ? '0 : cur_y_q + 1'b1;
      end else begin
        cur_x_d = cur_x_q + 1'b1;
      end
      if (last_x && last_y) begin
        diff_d           = cnt_inc;
        cnt_d            = '0;
        frame_done_d     = 1'b1;
        refresh_active_d = 1'b0;
      end else begin
        cnt_d = cnt_inc;
      end
    end
    if (bus.refresh) refresh_pend_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_x_q          <= '0;
      cur_y_q          <= '0;
      upd_valid_q      <= 1'b0;
      upd_x_q          <= '0;
      upd_y_q          <= '0;
      upd_code_q       <= '0;
      cnt_q            <= '0;
      diff_q           <= '0;
      frame_done_q     <= 1'b0;
      refresh_pend_q   <= 1'b0;
      refresh_active_q <= 1'b0;
    end else begin
      cur_x_q          <= cur_x_d;
      cur_y_q          <= cur_y_d;
      upd_valid_q      <= upd_valid_d;
      upd_x_q          <= upd_x_d;
      upd_y_q          <= upd_y_d;
      upd_code_q       <= upd_code_d;
      cnt_q            <= cnt_d;
      diff_q           <= diff_d;
      frame_done_q     <= frame_done_d;
      refresh_pend_q   <= refresh_pend_d;
      refresh_active_q <= refresh_active_d;
    end
  end

  assign bus.scan_ready = scan_ready;
  assign bus.cur_x      = cur_x_q;
  assign bus.cur_y      = cur_y_q;
  assign bus.upd_valid  = upd_valid_q;
  assign bus.upd_x      = upd_x_q;
  assign bus.upd_y      = upd_y_q;
  assign bus.upd_code   = upd_code_q;
  assign bus.frame_done = frame_done_q;
  assign bus.diff_count = diff_q;
endmodule

// File: tb/tb_grid_diff_tracker.sv
// Directed bench for grid_diff_tracker on the default 16x12 grid with four object lines.
module tb_grid_diff_tracker;
  localparam int GW = 16;
  localparam int GH = 12;
  localparam int CELLS = GW * GH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  grid_diff_tracker_if #(.N_OBJ(4), .XW(4), .YW(4), .CODE_W(3), .CW(8)) bus ();

  grid_diff_tracker #(.GRID_W(GW), .GRID_H(GH), .N_OBJ(4)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Handshake / frame monitor; tasks diff its running totals.
  int mon_upd = 0, mon_dup = 0, mon_prev_idx = -1;
  int mon_lx = 0, mon_ly = 0, mon_lc = 0;
  int mon_done = 0, mon_dc = 0, mon_acc = 0, mon_span = 0;

  always @(negedge clk) begin
    if (bus.upd_valid && bus.upd_ready) begin
      if (int'(bus.upd_y) * GW + int'(bus.upd_x) == mon_prev_idx) mon_dup <= mon_dup + 1;
      mon_prev_idx <= int'(bus.upd_y) * GW + int'(bus.upd_x);
      mon_upd <= mon_upd + 1;
      mon_lx  <= int'(bus.upd_x);
      mon_ly  <= int'(bus.upd_y);
      mon_lc  <= int'(bus.upd_code);
    end
    if (bus.frame_done) begin
      mon_done <= mon_done + 1;
      mon_dc   <= int'(bus.diff_count);
      mon_span <= mon_acc;
      mon_acc  <= (bus.enable && bus.scan_ready && !bus.clear) ? 1 : 0;
    end else if (bus.enable && bus.scan_ready && !bus.clear) begin
      mon_acc <= mon_acc + 1;
    end
  end

  function automatic logic [3:0] pat(input int mode, input int x, input int y);
    case (mode)
      1: return (x == 3 && y == 2) ? 4'b0001 : 4'b0000;
      2: return (x == 5 && y == 5) ? 4'b1010 : 4'b0000;
      3: return 4'b0110;
      4: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic idle(input int n);
    bus.enable = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive_frame(input int mode, input int start_k, input int refresh_k, input int clear_k);
    for (int k = start_k; k < CELLS; k++) begin
      bit acc;
      int guard;
      bus.enable  = 1'b1;
      bus.obj_req = pat(mode, k % GW, k / GW);
      bus.refresh = (k == refresh_k);
      bus.clear   = (k == clear_k);
      acc = 1'b0;
      guard = 0;
      while (!acc && guard < 50) begin
        @(negedge clk);
        acc = bus.scan_ready || bus.clear;
        @(posedge clk); #1;
        guard++;
      end
      bus.refresh = 1'b0;
      bus.clear   = 1'b0;
      if (!acc) begin
        n_checks++; n_fail++;
        $display("FAIL accept_timeout cell %0d never accepted within 50 cycles", k);
      end
      if (k == clear_k) break;
    end
    bus.enable = 1'b0;
  endtask

  task automatic check_frame(input string name, input int base_upd, input int base_done,
                             input int exp_upd, input int exp_dc);
    n_checks++;
    if (mon_upd - base_upd !== exp_upd) begin
      n_fail++; $display("FAIL %s_updates got %0d expected %0d", name, mon_upd - base_upd, exp_upd);
    end
    n_checks++;
    if (mon_done - base_done !== 1 || mon_dc !== exp_dc || int'(bus.diff_count) !== exp_dc) begin
      n_fail++;
      $display("FAIL %s_diff pulses %0d diff@done %0d diff_count %0d expected 1 pulse, %0d",
               name, mon_done - base_done, mon_dc, bus.diff_count, exp_dc);
    end
  endtask

  task automatic test_reset;
    bus.obj_req = '0; bus.enable = 1'b0; bus.clear = 1'b0; bus.refresh = 1'b0; bus.upd_ready = 1'b1;
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.upd_valid !== 1'b0 || bus.frame_done !== 1'b0 || bus.scan_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ctrl valid %b done %b ready %b expected 0 0 1",
                         bus.upd_valid, bus.frame_done, bus.scan_ready);
    end
    n_checks++;
    if (bus.cur_x !== 4'd0 || bus.cur_y !== 4'd0 || bus.diff_count !== 8'd0 ||
        bus.upd_x !== 4'd0 || bus.upd_y !== 4'd0 || bus.upd_code !== 3'd0) begin
      n_fail++; $display("FAIL reset_fields cur (%0d,%0d) diff %0d upd (%0d,%0d,%0d) expected all 0",
                         bus.cur_x, bus.cur_y, bus.diff_count, bus.upd_x, bus.upd_y, bus.upd_code);
    end
  endtask

  task automatic test_first_frame;
    int bu = mon_upd, bd = mon_done;
    drive_frame(1, 0, -1, -1);
    idle(3);
    check_frame("first", bu, bd, 1, 1);
    n_checks++;
    if (mon_lx !== 3 || mon_ly !== 2 || mon_lc !== 1) begin
      n_fail++; $display("FAIL first_update got (%0d,%0d,%0d) expected (3,2,1)", mon_lx, mon_ly, mon_lc);
    end
    n_checks++;
    if (bus.cur_x !== 4'd0 || bus.cur_y !== 4'd0) begin
      n_fail++; $display("FAIL cursor_wrap got (%0d,%0d) expected (0,0)", bus.cur_x, bus.cur_y);
    end
  endtask

  task automatic test_priority;
    int bu = mon_upd, bd = mon_done;
    drive_frame(2, 0, -1, -1);
    idle(3);
    // (3,2) returns to empty and (5,5) resolves 4'b1010 to code 4.
    check_frame("priority", bu, bd, 2, 2);
    n_checks++;
    if (mon_lx !== 5 || mon_ly !== 5 || mon_lc !== 4) begin
      n_fail++; $display("FAIL priority_code got (%0d,%0d,%0d) expected (5,5,4)", mon_lx, mon_ly, mon_lc);
    end
    bu = mon_upd; bd = mon_done;
    drive_frame(2, 0, -1, -1);
    idle(3);
    check_frame("repeat", bu, bd, 0, 0);
    n_checks++;
    if (mon_span !== CELLS) begin
      n_fail++; $display("FAIL accept_span got %0d expected %0d", mon_span, CELLS);
    end
  endtask

  task automatic test_backpressure;
    int bu = mon_upd, bd = mon_done, bdup = mon_dup;
    bus.enable = 1'b1; bus.obj_req = 4'b1111; bus.upd_ready = 1'b1;
    @(posedge clk); #1;
    bus.upd_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if (bus.scan_ready !== 1'b0 || bus.upd_valid !== 1'b1 || bus.cur_x !== 4'd1 || bus.cur_y !== 4'd0 ||
          bus.upd_x !== 4'd0 || bus.upd_y !== 4'd0 || bus.upd_code !== 3'd4) begin
        n_fail++;
        $display("FAIL stall_hold cyc %0d ready %b valid %b cur (%0d,%0d) upd (%0d,%0d,%0d) expected 0 1 (1,0) (0,0,4)",
                 c, bus.scan_ready, bus.upd_valid, bus.cur_x, bus.cur_y, bus.upd_x, bus.upd_y, bus.upd_code);
      end
      @(posedge clk); #1;
    end
    bus.upd_ready = 1'b1;
    drive_frame(4, 1, -1, -1);
    idle(3);
    // Every cell except (5,5), which already held code 4.
    check_frame("backpressure", bu, bd, CELLS - 1, CELLS - 1);
    n_checks++;
    if (mon_dup - bdup !== 0) begin
      n_fail++; $display("FAIL stall_duplicates got %0d expected 0", mon_dup - bdup);
    end
  endtask

  task automatic test_refresh;
    int bu = mon_upd, bd = mon_done;
    drive_frame(4, 0, 50, -1);
    idle(3);
    check_frame("refresh_cur", bu, bd, 0, 0);
    bu = mon_upd; bd = mon_done;
    drive_frame(4, 0, -1, -1);
    idle(3);
    check_frame("refresh_full", bu, bd, CELLS, CELLS);
    bu = mon_upd; bd = mon_done;
    drive_frame(4, 0, -1, -1);
    idle(3);
    check_frame("refresh_after", bu, bd, 0, 0);
  endtask

  task automatic test_clear;
    int bu, bd = mon_done;
    drive_frame(3, 0, -1, 3 * GW + 7);
    n_checks++;
    if (bus.cur_x !== 4'd0 || bus.cur_y !== 4'd0 || bus.upd_valid !== 1'b0) begin
      n_fail++; $display("FAIL clear_state cur (%0d,%0d) valid %b expected (0,0) 0",
                         bus.cur_x, bus.cur_y, bus.upd_valid);
    end
    idle(3);
    n_checks++;
    if (mon_done - bd !== 0 || bus.diff_count !== 8'd0) begin
      n_fail++; $display("FAIL clear_no_done pulses %0d diff %0d expected 0 0", mon_done - bd, bus.diff_count);
    end
    bu = mon_upd; bd = mon_done;
    drive_frame(0, 0, -1, -1);
    idle(3);
    check_frame("clear_zero", bu, bd, 0, 0);
    bu = mon_upd; bd = mon_done;
    drive_frame(4, 0, -1, -1);
    idle(3);
    check_frame("clear_full", bu, bd, CELLS, CELLS);
  endtask

  task automatic test_reset_stall;
    int bu, bd;
    bus.enable = 1'b1; bus.obj_req = 4'b0000; bus.upd_ready = 1'b1;
    @(posedge clk); #1;
    bus.upd_ready = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    n_checks++;
    if (bus.upd_valid !== 1'b1 || bus.cur_x !== 4'd1) begin
      n_fail++; $display("FAIL stall_setup valid %b cur_x %0d expected 1 1", bus.upd_valid, bus.cur_x);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.upd_valid !== 1'b0 || bus.cur_x !== 4'd0 || bus.cur_y !== 4'd0 ||
        bus.diff_count !== 8'd0 || bus.scan_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_stall valid %b cur (%0d,%0d) diff %0d ready %b expected 0 (0,0) 0 1",
                         bus.upd_valid, bus.cur_x, bus.cur_y, bus.diff_count, bus.scan_ready);
    end
    bus.enable = 1'b0; bus.upd_ready = 1'b1;
    rst = 1'b0;
    bu = mon_upd; bd = mon_done;
    drive_frame(0, 0, -1, -1);
    idle(3);
    check_frame("post_reset", bu, bd, 0, 0);
  endtask

  initial begin
    test_reset;
    test_first_frame;
    test_priority;
    test_backpressure;
    test_refresh;
    test_clear;
    test_reset_stall;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/grid_diff_tracker.md
# grid_diff_tracker

Parametrised shadow-frame tracker for the tile-based renderer. Walks a GRID_W x GRID_H cell grid in raster order, resolves the per-cell object request bits to an object code, and compares it against a stored copy of the previous frame. Each changed cell is written back and emitted as a registered (x, y, code) update over a valid/ready handshake to the downstream drawing engine. Adds backpressure, a full-frame forced refresh, and per-frame change statistics.

## Interface
- GRID_W, 16, cells per row (>= 2)
- GRID_H, 12, rows per frame (>= 2)
- N_OBJ, 4, number of object request lines; CODE_W = $clog2(N_OBJ+1), XW = $clog2(GRID_W), YW = $clog2(GRID_H), CW = $clog2(GRID_W*GRID_H+1)
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- obj_req  in  N_OBJ  object present at current cell; bit i means code i+1; highest set bit wins; none means code 0
- enable  in  1  offer obj_req for the current cell
- scan_ready  out  1  cell accepted this cycle when enable && scan_ready
- clear  in  1  zero the stored frame, return cursor to (0,0)
- refresh  in  1  pulse: next full frame reports every cell
- cur_x / cur_y  out  XW / YW  cursor of the cell being offered
- upd_valid  out  1  update pending
- upd_ready  in  1  downstream accepts update
- upd_x / upd_y / upd_code  out  XW / YW / CODE_W  changed cell and its new code
- frame_done  out  1  one-cycle pulse after the last cell of a frame is accepted
- diff_count  out  CW  number of updates generated in the last completed frame

## Operation
- Reset: all cells 0, cursor (0,0), upd_valid 0, upd_x/y/code 0, frame_done 0, diff_count 0, refresh pending/active 0. scan_ready is 1 after reset.
- scan_ready = !(upd_valid && !upd_ready). A stalled update blocks acceptance; no cell is skipped or dropped.
- On accept:
  - new = resolved code; old = stored[cur_x][cur_y]; stored cell <= new.
  - If new != old or refresh_active: upd_valid <= 1 and upd_x/y/code <= cursor/new. Otherwise upd_valid <= 0 unless a held update is still waiting.
  - Cursor advances raster-order: x+1; at x = GRID_W-1, x <= 0 and y+1; at (GRID_W-1, GRID_H-1), wrap to (0,0).
- Update handshake: upd_valid stays high with stable fields until upd_valid && upd_ready. Without a new accept, the handshake cycle clears upd_valid next cycle.
- Refresh:
  - refresh sets refresh_pend.
  - The accept of (0,0) with refresh_pend set sets refresh_active for that whole frame, and that accept already reports. refresh_pend clears at the same time.
  - refresh_active clears after accepting (GRID_W-1, GRID_H-1). Cells still write normally.
- Statistics: a per-frame counter counts updates generated. At the last-cell accept, diff_count <= counter (including this cell), the counter <= 0, and frame_done pulses next cycle. The counter saturates at GRID_W*GRID_H.
- Clear has priority over accept in the same cycle: the accepted cell is discarded.
  - Memory, cursor, and counter go to 0; any pending update is dropped (upd_valid <= 0).
  - refresh_pend/active are kept, diff_count holds, and no frame_done is generated.
- Codes above N_OBJ cannot occur; stored values are always legal.

## Timing
- Update latency: exactly 1 cycle from accept to upd_valid.
- Cursor outputs change on the cycle after accept; obj_req must match the cursor shown in the accept cycle.
- Full throughput, 1 cell/clk, when upd_ready is held high.
- rst mid-frame gives the same state as power-up reset on the next edge.
- frame_done and the new diff_count appear in the same cycle.

## Structure
- Package grid_tracker_pkg: default GRID_W/GRID_H/N_OBJ, the CODE_W/XW/YW/CW width functions, and a code_t constant set (EMPTY=0, and so on) shared with the renderer.
- Sub-module grid_shadow_mem holds the GRID_W*GRID_H x CODE_W register array:
  - one combinational read port at the cursor
  - one synchronous write port
  - a synchronous bulk-clear input
- Top level holds the cursor, the priority encoder, compare/update register, handshake, refresh, and statistics logic.

## Test plan
- First frame after reset, obj_req = 4'b0001 on (3,2) only, upd_ready = 1: one update (3,2,1). diff_count = 1 at frame_done. 192 accepts between frame_done pulses.
- Priority: obj_req = 4'b1010 at (5,5) gives code 4. Repeat the next frame with the same input: no update and diff_count = 0.
- Backpressure: upd_ready = 0 for 5 cycles after an update at (0,0), enable held high. scan_ready drops, the cursor holds at (1,0), and the update fields stay stable. After release there are no lost or duplicated updates.
- Refresh pulsed mid-frame with static input: the rest of the current frame reports only changes. The next frame reports all 192 cells and diff_count = 192. The following frame gives 0.
- Clear asserted at cursor (7,3) with enable high: the cursor goes to (0,0) and upd_valid goes to 0. A subsequent frame of all-zero obj_req gives diff_count = 0; all-nonzero gives 192.
- Reset asserted mid-stall with upd_valid = 1: next cycle upd_valid = 0, cursor (0,0), diff_count = 0, scan_ready = 1.
